// File: rtl/teal_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : teal_mem_arbiter                                           |
// | Description : Round-robin arbiter and sequencer that shares one          |
// |               single-port memory interface among NUM_REQ requesters.     |
// |               Accepts at most one request per cycle, issues it on the    |
// |               memory port one cycle later, and returns every access's    |
// |               completion (with read data for reads) to its requester,    |
// |               in issue order, RD_LATENCY+1 cycles after issue.           |
// | Ports       : clk, reset            - clock, sync active-high reset      |
// |               req_valid/write/addr/wdata - packed per-requester requests |
// |               req_ready             - one-hot grant                      |
// |               rsp_valid, rsp_rdata  - one-hot completion + read data     |
// |               mem_en/we/addr/wdata  - memory command port                |
// |               mem_rdata             - memory read data                   |
// |               busy, txn_count       - activity flag, issued-txn counter  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module teal_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [15:0]               txn_count
);

  localparam int                c_ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_ID_W:0]   c_NUM_REQ_EXT = (c_ID_W+1)'(NUM_REQ);
  localparam logic [c_ID_W-1:0] c_LAST_ID     = c_ID_W'(NUM_REQ - 1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("teal_mem_arbiter: NUM_REQ must be in 2..8");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_rd_latency
      $error("teal_mem_arbiter: RD_LATENCY must be in 1..8");
    end
  endgenerate

  // ------------------------------------------------------------------
  // Registered state
  // ------------------------------------------------------------------
  logic [c_ID_W-1:0]  r_rr_ptr;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [c_ID_W-1:0]  r_mem_id;
  logic [15:0]        r_txn_count;

  logic [RD_LATENCY-1:0] r_pipe_v;
  logic [RD_LATENCY-1:0] r_pipe_we;
  logic [c_ID_W-1:0]     r_pipe_id [RD_LATENCY];

  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;

  // ------------------------------------------------------------------
  // Round-robin search: first valid index at or after r_rr_ptr, wrapping.
  // The index is kept one bit wider so the wrap is a single subtract,
  // which also covers non-power-of-two NUM_REQ.
  // ------------------------------------------------------------------
  logic               w_found;
  logic [c_ID_W-1:0]  w_gnt_id;
  logic [c_ID_W:0]    w_idx;

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
      if (w_idx >= c_NUM_REQ_EXT) begin
        w_idx = w_idx - c_NUM_REQ_EXT;
      end
      if (!w_found && req_valid[w_idx[c_ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[c_ID_W-1:0];
      end
    end
  end

  // No grant while reset is asserted so nothing is accepted and then lost.
  logic               w_accept;
  logic [NUM_REQ-1:0] w_gnt;
  logic [c_ID_W-1:0]  w_next_ptr;

  assign w_accept   = w_found && !reset;
  assign w_next_ptr = (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt[i] = w_accept && (w_gnt_id == c_ID_W'(i));
    end
  end

  // Payload mux for the granted requester
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_id == c_ID_W'(i)) begin
        w_sel_we    = req_write[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // ------------------------------------------------------------------
  // Issue stage: drives the memory port one cycle after acceptance.
  // Address and write data hold when idle; only the strobes drop.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_id    <= '0;
      r_txn_count <= '0;
    end else begin
      r_mem_en <= w_accept;
      if (w_accept) begin
        r_mem_we    <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_id    <= w_gnt_id;
        r_rr_ptr    <= w_next_ptr;
        r_txn_count <= r_txn_count + 16'd1;
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Tracking pipeline: stage 0 captures the access currently on the
  // memory port, so the last stage lines up with mem_rdata for it.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_v  <= '0;
      r_pipe_we <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_id[i] <= '0;
      end
    end else begin
      r_pipe_v[0]  <= r_mem_en;
      r_pipe_we[0] <= r_mem_we;
      r_pipe_id[0] <= r_mem_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_v[i]  <= r_pipe_v[i-1];
        r_pipe_we[i] <= r_pipe_we[i-1];
        r_pipe_id[i] <= r_pipe_id[i-1];
      end
    end
  end

  // ------------------------------------------------------------------
  // Registered response: one-hot pulse, read data zeroed for writes
  // and whenever no response is presented.
  // ------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_rsp_hot;

  always_comb begin
    w_rsp_hot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_hot[i] = r_pipe_v[RD_LATENCY-1] &&
                     (r_pipe_id[RD_LATENCY-1] == c_ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rsp_hot;
      r_rsp_rdata <= (r_pipe_v[RD_LATENCY-1] && !r_pipe_we[RD_LATENCY-1]) ?
                     mem_rdata : '0;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign txn_count = r_txn_count;
  assign busy      = r_mem_en || (|r_pipe_v) || (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_teal_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_teal_mem_arbiter                                        |
// | Description : Self-checking bench for teal_mem_arbiter: memory model,    |
// |               transaction-level reference model, vector table, directed |
// |               corner sequences and randomized traffic.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_teal_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [15:0]     txn_count;

  always #5 clk = ~clk;

  teal_mem_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .txn_count(txn_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Memory model: samples the port at each edge, read data appears
  // L cycles later; junk is driven when no read data is due.
  // ------------------------------------------------------------------
  logic [DW-1:0] env_mem [logic [31:0]];
  logic [L-1:0]  p_v = '0;
  logic [DW-1:0] p_d [L];

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
    p_v[0] <= mem_en && !mem_we;
    p_d[0] <= rd;
    for (int i = 1; i < L; i++) begin
      p_v[i] <= p_v[i-1];
      p_d[i] <= p_d[i-1];
    end
  end

  assign mem_rdata = p_v[L-1] ? p_d[L-1] : 32'hA5A5_5A5A;

  // ------------------------------------------------------------------
  // Reference model: transaction level. Each accepted request becomes
  // an expected response due a fixed number of cycles later; memory
  // contents are tracked as a plain associative array in issue order.
  // ------------------------------------------------------------------
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [logic [31:0]];
  int            cyc     = 0;
  int            m_ptr   = 0;
  logic [15:0]   m_txn   = '0;
  logic          m_en    = 1'b0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;

  // One clock cycle: inputs already driven; checks grant, advances the
  // model across the edge, then checks all registered outputs.
  task automatic step(input bit rst_now, output int g, output logic [N-1:0] seen);
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] rd;
    reset = rst_now;
    #1;
    g = -1;
    if (!rst_now) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    seen = req_ready;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk);
    cyc++;
    if (rst_now) begin
      m_ptr = 0; m_txn = '0; m_en = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0;
      sb.delete();
    end else if (g >= 0) begin
      m_en    = 1'b1;
      m_we    = req_write[g];
      m_addr  = req_addr[g*AW +: AW];
      m_wdata = req_wdata[g*DW +: DW];
      m_ptr   = (g + 1) % N;
      m_txn   = m_txn + 16'd1;
      if (m_we) begin
        ref_mem[m_addr] = m_wdata;
        rd = '0;
      end else begin
        rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : '0;
      end
      sb.push_back('{due: cyc + L + 1, id: g, rdata: rd});
    end else begin
      m_en = 1'b0;
      m_we = 1'b0;
    end
    while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_rv = N'(1) << sb[0].id;
      exp_rd = sb[0].rdata;
    end else begin
      exp_rv = '0;
      exp_rd = '0;
    end
    chk("mem_en",    mem_en,    m_en);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("txn_count", txn_count, m_txn);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("busy",      busy,      sb.size() != 0);
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // ------------------------------------------------------------------
  // Vector table: request pattern held one cycle, expected grant.
  // Pointer evolution starting from 0 after reset is folded into the
  // expected column.
  // ------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] write;
    logic [N-1:0] exp_ready;
  } vec_t;

  vec_t vt[12];

  initial begin
    int           g;
    logic [N-1:0] seen;
    int           order[$];

    vt[0]  = '{4'b0000, 4'b0000, 4'b0000};  // ptr 0
    vt[1]  = '{4'b0100, 4'b0100, 4'b0100};  // ptr 0 -> 3
    vt[2]  = '{4'b1111, 4'b0000, 4'b1000};  // ptr 3 -> 0
    vt[3]  = '{4'b1111, 4'b1010, 4'b0001};  // ptr 0 -> 1
    vt[4]  = '{4'b0001, 4'b0000, 4'b0001};  // ptr 1 wraps to 0 -> 1
    vt[5]  = '{4'b1001, 4'b1001, 4'b1000};  // ptr 1 -> 0
    vt[6]  = '{4'b0110, 4'b0000, 4'b0010};  // ptr 0 -> 2
    vt[7]  = '{4'b0011, 4'b0001, 4'b0001};  // ptr 2 wraps to 0 -> 1
    vt[8]  = '{4'b0000, 4'b0000, 4'b0000};  // ptr 1
    vt[9]  = '{4'b1010, 4'b0000, 4'b0010};  // ptr 1 -> 2
    vt[10] = '{4'b1010, 4'b0000, 4'b1000};  // ptr 2 -> 0
    vt[11] = '{4'b0110, 4'b0100, 4'b0010};  // ptr 0 -> 2

    // Reset state
    step(1'b1, g, seen);
    step(1'b1, g, seen);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_txn",   txn_count, 16'h0000);
    chk("rst_mem_en", mem_en,   1'b0);

    // Table-driven grants
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, vt[v].valid[i], vt[v].write[i], 32'(i * 4 + v * 16), 32'($urandom()));
      end
      step(1'b0, g, seen);
      chk("tbl_ready", seen, vt[v].exp_ready);
      chk("tbl_mem_en", mem_en, |vt[v].exp_ready);
    end
    req_valid = '0;
    for (int k = 0; k < L + 2; k++) step(1'b0, g, seen);

    // A: single read from requester 2 at 0x40
    step(1'b1, g, seen);
    env_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;
    set_req(2, 1'b1, 1'b0, 32'h40, '0);
    step(1'b0, g, seen);
    req_valid = '0;
    chk("A_grant", seen, 4'b0100);
    chk("A_mem_en", mem_en, 1'b1);
    chk("A_mem_addr", mem_addr, 32'h40);
    chk("A_mem_we", mem_we, 1'b0);
    step(1'b0, g, seen);
    chk("A_rsp_early1", rsp_valid, 4'b0000);
    step(1'b0, g, seen);
    chk("A_rsp_early2", rsp_valid, 4'b0000);
    step(1'b0, g, seen);
    chk("A_rsp_valid", rsp_valid, 4'b0100);
    chk("A_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("A_txn", txn_count, 16'd1);
    chk("A_busy_hi", busy, 1'b1);
    step(1'b0, g, seen);
    chk("A_busy_lo", busy, 1'b0);
    chk("A_rdata_zero", rsp_rdata, 32'h0);

    // B: all four requesters hold reads for 8 cycles
    step(1'b1, g, seen);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(32'h100 + i * 4), '0);
    for (int k = 0; k < 8 + L + 3; k++) begin
      if (k == 8) req_valid = '0;
      step(1'b0, g, seen);
      if (k < 8) begin
        chk("B_grant", seen, N'(1) << (k % N));
        chk("B_mem_en", mem_en, 1'b1);
      end
      if (k == 8) chk("B_txn", txn_count, 16'd8);
      for (int i = 0; i < N; i++) if (rsp_valid[i]) order.push_back(i);
    end
    chk("B_rsp_count", order.size(), 8);
    for (int k = 0; k < order.size() && k < 8; k++) chk("B_rsp_order", order[k], k % N);

    // C: requester 1 writes, requester 3 reads back
    set_req(1, 1'b1, 1'b1, 32'h10, 32'h12345678);
    step(1'b0, g, seen);
    req_valid = '0;
    chk("C_wr_grant", seen, 4'b0010);
    set_req(3, 1'b1, 1'b0, 32'h10, '0);
    step(1'b0, g, seen);
    req_valid = '0;
    chk("C_rd_grant", seen, 4'b1000);
    step(1'b0, g, seen);
    step(1'b0, g, seen);
    chk("C_wack_valid", rsp_valid, 4'b0010);
    chk("C_wack_rdata", rsp_rdata, 32'h0);
    step(1'b0, g, seen);
    chk("C_rd_valid", rsp_valid, 4'b1000);
    chk("C_rd_rdata", rsp_rdata, 32'h12345678);
    chk("C_mem_content", env_mem.exists(32'h10) ? env_mem[32'h10] : 32'h0, 32'h12345678);
    for (int k = 0; k < L + 1; k++) step(1'b0, g, seen);

    // D: only requester 0 valid for 5 cycles, then everyone
    step(1'b1, g, seen);
    set_req(0, 1'b1, 1'b0, 32'h20, '0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, g, seen);
      chk("D_grant0", seen, 4'b0001);
      chk("D_mem_en", mem_en, 1'b1);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'(32'h20 + i * 4), '0);
    step(1'b0, g, seen);
    req_valid = '0;
    chk("D_ptr_after", seen, 4'b0010);
    chk("D_txn", txn_count, 16'd6);
    for (int k = 0; k < L + 2; k++) step(1'b0, g, seen);

    // E: reset with two reads in flight
    step(1'b1, g, seen);
    set_req(0, 1'b1, 1'b0, 32'h40, '0);
    set_req(1, 1'b1, 1'b0, 32'h10, '0);
    step(1'b0, g, seen);
    req_valid[0] = 1'b0;
    step(1'b0, g, seen);
    req_valid = '0;
    step(1'b1, g, seen);
    chk("E_busy", busy, 1'b0);
    chk("E_txn", txn_count, 16'd0);
    for (int k = 0; k < L + 3; k++) begin
      step(1'b0, g, seen);
      chk("E_no_rsp", rsp_valid, 4'b0000);
    end
    set_req(2, 1'b1, 1'b0, 32'h40, '0);
    step(1'b0, g, seen);
    req_valid = '0;
    chk("E_new_grant", seen, 4'b0100);
    for (int k = 0; k < L + 1; k++) step(1'b0, g, seen);
    chk("E_new_rsp", rsp_valid, 4'b0100);
    chk("E_new_rdata", rsp_rdata, 32'hDEADBEEF);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          set_req(i, 1'b1, 1'($urandom_range(1)), 32'($urandom_range(15)) * 32'd4, 32'($urandom()));
        end
      end
      step($urandom_range(99) == 0, g, seen);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    req_valid = '0;
    for (int k = 0; k < L + 2; k++) step(1'b0, g, seen);

    // F: txn_count wrap
    step(1'b1, g, seen);
    set_req(0, 1'b1, 1'b0, 32'h0, '0);
    for (int k = 0; k < 65535; k++) step(1'b0, g, seen);
    chk("F_txn_ffff", txn_count, 16'hFFFF);
    step(1'b0, g, seen);
    chk("F_txn_0000", txn_count, 16'h0000);
    step(1'b0, g, seen);
    chk("F_txn_0001", txn_count, 16'h0001);
    req_valid = '0;
    for (int k = 0; k < L + 2; k++) step(1'b0, g, seen);
    chk("F_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/teal_mem_arbiter.md
Name: teal_mem_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one single-port memory/register interface among NUM_REQ transaction requesters (BFM drivers, register-access masters).
- Serialises requests onto the shared memory port at up to one per cycle.
- Tracks in-flight accesses in a latency pipeline and routes each response back to the requester that issued it, in issue order.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LATENCY, 2, cycles from mem_en sampled high to mem_rdata valid (1..8).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_write  input  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  NUM_REQ  one-hot completion pulse.
- rsp_rdata  output  DATA_W  read data, qualified by rsp_valid.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid RD_LATENCY cycles after mem_en.
- busy  output  1  high while any access is in flight or on the memory port.
- txn_count  output  16  count of issued transactions; wraps at 0xFFFF to 0.

Behaviour:
- Reset (sampled high at a clk edge): req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, txn_count=0, rr_ptr=0, in-flight pipeline cleared.
- Reset asserted mid-operation: pending responses are dropped, never delivered; mem_rdata is ignored until new issues.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first valid index g gets req_ready[g]=1; all other req_ready bits are 0.
  - No valid requests: req_ready=0.
  - req_ready never depends on memory state; the memory port never back-pressures.
- Requester rule: req_valid and its payload hold stable until accepted. Dropping req_valid before acceptance is legal; that request is simply not issued.
- Issue, at the edge after acceptance of g:
  - mem_en=1; mem_we=req_write[g]; mem_addr and mem_wdata = slice g.
  - rr_ptr=(g+1) mod NUM_REQ.
  - txn_count increments by 1.
- No acceptance in a cycle: mem_en=0 next cycle; mem_we=0; mem_addr/mem_wdata hold their last values.
- Issue latency: 1 cycle. Throughput: 1 transaction per cycle. Back-to-back grants to the same requester happen only when no other requester is valid.
- Tracking: a shift pipeline of depth RD_LATENCY carries {valid, requester id, write flag} per issued access.
- Completion, for every access (read or write), RD_LATENCY+1 cycles after mem_en was high (one pipeline stage plus a registered output):
  - rsp_valid[id] pulses for exactly 1 cycle.
  - rsp_rdata = mem_rdata sampled RD_LATENCY cycles after that mem_en for reads; 0 for writes.
  - rsp_rdata=0 whenever rsp_valid=0.
- Ordering: responses return strictly in issue order; at most one rsp_valid bit per cycle.
- busy = mem_en OR any valid pipeline stage OR any rsp_valid bit.
- Simultaneous requests from all NUM_REQ requesters: grants rotate 0,1,..,NUM_REQ-1,0,... with no starvation. Worst-case wait is NUM_REQ-1 cycles.
- Simultaneous acceptance and completion in the same cycle: independent, no stall.
- rr_ptr wrap: after a grant to NUM_REQ-1, rr_ptr=0.
- Illegal parameters (NUM_REQ outside 2..8, RD_LATENCY outside 1..8): elaboration-time error.

Test Plan:
- Reset, then single read from requester 2 at address 0x40 with a memory model returning 0xDEADBEEF: mem_en high 1 cycle after grant with mem_addr=0x40, mem_we=0; rsp_valid=4'b0100 with rsp_rdata=0xDEADBEEF exactly 3 cycles after mem_en; txn_count=1; busy falls the cycle after rsp_valid.
- All 4 requesters hold reads for 8 cycles: grant sequence 0,1,2,3,0,1,2,3; mem_en continuous; rsp_valid order matches grant order; txn_count=8.
- Requester 1 writes 0x12345678 to 0x10, then requester 3 reads 0x10: memory contains 0x12345678; write ack rsp_rdata=0; read returns 0x12345678 one cycle after the write ack.
- Only requester 0 valid for 5 cycles: granted every cycle, 5 back-to-back issues, rr_ptr=1 afterwards.
- Reset asserted while 2 reads are in flight: no rsp_valid pulses after reset; busy=0 and txn_count=0 the cycle after reset; the next read completes normally.
- Preload txn_count near wrap (issue 65535 transactions, then 2 more): txn_count reads 0xFFFF, then 0x0000, then 0x0001.
